// File: rtl/uart_tx_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buf_if
// Purpose  : Register-side push/status bundle of the buffered UART transmitter.
// Revision : 1.0
// ============================================================================
interface uart_tx_buf_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

   logic            wr_i;
   logic [7:0]      wdata_i;
   logic            ovf_clr_i;
   logic            full_o;
   logic            empty_o;
   logic [c_LW-1:0] level_o;
   logic            busy_o;
   logic            ovf_o;

   modport master (
      output wr_i, wdata_i, ovf_clr_i,
      input  full_o, empty_o, level_o, busy_o, ovf_o
   );

   modport slave (
      input  wr_i, wdata_i, ovf_clr_i,
      output full_o, empty_o, level_o, busy_o, ovf_o
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buf
// Purpose  : Byte FIFO feeding an 8N1 UART serialiser at a fixed baud rate.
// Revision : 1.0
// ============================================================================
module uart_tx_buf #(
   parameter int CLK_FREQ       = 10_000_000,
   parameter int UART_BAUD_RATE = 115200,
   parameter int FIFO_DEPTH     = 16
) (
   input  wire logic    clk_i,
   input  wire logic    rst_ni,
   uart_tx_buf_if.slave bus,
   output logic         tx_o
);
   localparam int c_DIV = (CLK_FREQ + UART_BAUD_RATE / 2) / UART_BAUD_RATE;
   localparam int c_AW  = $clog2(FIFO_DEPTH);
   localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(c_DIV - 1);

   generate
      if (c_DIV < 2) begin : g_div_check
         $error("uart_tx_buf: baud divisor must be at least 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
         $error("uart_tx_buf: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [c_AW:0]   r_count;
   logic            r_ovf;

   state_t          r_state, w_state_nx;
   logic [c_CW-1:0] r_cnt, w_cnt_nx;
   logic [2:0]      r_idx, w_idx_nx;
   logic [7:0]      r_shift, w_shift_nx;
   logic            r_tx, w_tx_nx;

   logic w_full, w_empty, w_push, w_drop, w_pop, w_cnt_end;

   assign w_full    = (r_count == c_DEPTH);
   assign w_empty   = (r_count == '0);
   assign w_push    = bus.wr_i & ~w_full;
   assign w_drop    = bus.wr_i &  w_full;
   assign w_cnt_end = (r_cnt == c_CNT_MAX);

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= bus.wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
         // A dropped write outranks a clear in the same cycle
         if (w_drop)             r_ovf <= 1'b1;
         else if (bus.ovf_clr_i) r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
         r_shift <= w_shift_nx;
         r_tx    <= w_tx_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_idx_nx   = r_idx;
      w_shift_nx = r_shift;
      w_pop      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_shift_nx = r_mem[r_rptr];
               w_cnt_nx   = '0;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            if (w_cnt_end) begin
               w_cnt_nx   = '0;
               w_idx_nx   = '0;
               w_state_nx = S_DATA;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (w_cnt_end) begin
               w_cnt_nx   = '0;
               w_shift_nx = {1'b0, r_shift[7:1]};
               if (r_idx == 3'd7) w_state_nx = S_STOP;
               else               w_idx_nx   = r_idx + 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (w_cnt_end) begin
               w_cnt_nx = '0;
               // Chain straight into the next frame when more data is waiting
               if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_shift_nx = r_mem[r_rptr];
                  w_state_nx = S_START;
               end else begin
                  w_state_nx = S_IDLE;
               end
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      // Line level is registered, so it is computed from the next state
      case (w_state_nx)
         S_START: w_tx_nx = 1'b0;
         S_DATA:  w_tx_nx = w_shift_nx[0];
         default: w_tx_nx = 1'b1;
      endcase
   end

   assign bus.full_o  = w_full;
   assign bus.empty_o = w_empty;
   assign bus.level_o = r_count;
   assign bus.busy_o  = (r_state != S_IDLE);
   assign bus.ovf_o   = r_ovf;
   assign tx_o        = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buf
// Purpose  : Randomised scoreboard bench for uart_tx_buf with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_buf;
   localparam int DEPTH = 4;
   localparam int DIV   = 10;
   localparam int FRAME = 10 * DIV;
   localparam int DDIV  = 87;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic tx, tx2;

   always #5 clk = ~clk;

   uart_tx_buf_if #(.FIFO_DEPTH(DEPTH)) bus ();
   uart_tx_buf_if #(.FIFO_DEPTH(16))    bus2 ();

   uart_tx_buf #(.CLK_FREQ(1_000_000), .UART_BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .tx_o(tx));

   uart_tx_buf u_dut_def (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus2), .tx_o(tx2));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: pending bytes, the byte on the line and cycles left in its frame
   logic [7:0] mq[$];
   logic [7:0] sb_q[$];
   logic [7:0] cur      = 8'h00;
   int         frame_left = 0;
   bit         m_ovf    = 1'b0;
   int         m_pre;
   bit         m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         sb_q.delete();
         frame_left = 0;
         m_ovf      = 1'b0;
      end else begin
         m_pre = mq.size();
         m_pop = (m_pre > 0) && (frame_left <= 1);
         if (bus.wr_i && m_pre >= DEPTH) m_ovf = 1'b1;
         else if (bus.ovf_clr_i)         m_ovf = 1'b0;
         if (m_pop) begin
            cur        = mq.pop_front();
            frame_left = FRAME;
         end else if (frame_left > 0) begin
            frame_left--;
         end
         if (bus.wr_i && m_pre < DEPTH) begin
            mq.push_back(bus.wdata_i);
            sb_q.push_back(bus.wdata_i);
         end
      end
   end

   function automatic logic exp_tx();
      int k;
      if (frame_left == 0) return 1'b1;
      k = (FRAME - frame_left) / DIV;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return cur[k-1];
   endfunction

   bit chk_en    = 1'b0;
   int busy_cnt  = 0;
   int busy2_cnt = 0;

   always @(negedge clk) begin
      if (bus.busy_o)  busy_cnt++;
      if (bus2.busy_o) busy2_cnt++;
      if (chk_en) begin
         chk("tx",    32'(tx),          32'(exp_tx()));
         chk("level", 32'(bus.level_o), 32'(mq.size()));
         chk("full",  32'(bus.full_o),  32'(mq.size() == DEPTH));
         chk("empty", 32'(bus.empty_o), 32'(mq.size() == 0));
         chk("busy",  32'(bus.busy_o),  32'(frame_left != 0));
         chk("ovf",   32'(bus.ovf_o),   32'(m_ovf));
      end
   end

   // Line monitor: decodes frames at mid-bit and checks them against the scoreboard
   bit         mon_on = 1'b0;
   int         mon_t  = 0;
   int         mon_k;
   logic [7:0] mon_b  = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_on = 1'b0;
      end else if (!mon_on) begin
         if (tx == 1'b0) begin
            mon_on = 1'b1;
            mon_t  = 0;
         end
      end else begin
         mon_t++;
         if (mon_t >= DIV / 2 && (mon_t - DIV / 2) % DIV == 0) begin
            mon_k = (mon_t - DIV / 2) / DIV;
            if (mon_k == 0) begin
               chk("start_bit", 32'(tx), 32'(0));
            end else if (mon_k <= 8) begin
               mon_b[mon_k-1] = tx;
            end else begin
               chk("stop_bit", 32'(tx), 32'(1));
               chk("frame_queued", 32'(sb_q.size() != 0), 32'(1));
               if (sb_q.size() != 0) chk("frame_data", 32'(mon_b), 32'(sb_q.pop_front()));
               mon_on = 1'b0;
            end
         end
      end
   end

   task automatic cyc(input bit w, input logic [7:0] d, input bit c);
      bus.wr_i      = w;
      bus.wdata_i   = d;
      bus.ovf_clr_i = c;
      @(posedge clk);
      #1;
      bus.wr_i      = 1'b0;
      bus.ovf_clr_i = 1'b0;
   endtask

   task automatic wait_idle(input int exp_busy, input string name);
      int i;
      for (i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (frame_left == 0 && mq.size() == 0) break;
      end
      chk("idle_timeout", 32'(i < 30000), 32'(1));
      repeat (DIV) @(negedge clk);
      #1;
      if (exp_busy >= 0) chk(name, 32'(busy_cnt), 32'(exp_busy));
   endtask

   initial begin
      int nxt;
      int guard;
      logic [7:0] dbyte;
      bus.wr_i  = 1'b0; bus.wdata_i  = 8'h00; bus.ovf_clr_i  = 1'b0;
      bus2.wr_i = 1'b0; bus2.wdata_i = 8'h00; bus2.ovf_clr_i = 1'b0;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx",    32'(tx),          32'(1));
      chk("rst_full",  32'(bus.full_o),  32'(0));
      chk("rst_empty", 32'(bus.empty_o), 32'(1));
      chk("rst_level", 32'(bus.level_o), 32'(0));
      chk("rst_busy",  32'(bus.busy_o),  32'(0));
      chk("rst_ovf",   32'(bus.ovf_o),   32'(0));
      #3 rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      busy_cnt = 0;
      cyc(1'b1, 8'hA5, 1'b0);
      wait_idle(FRAME, "busy_single");

      busy_cnt = 0;
      cyc(1'b1, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 1'b0);
      cyc(1'b1, 8'h55, 1'b0);
      wait_idle(3 * FRAME, "busy_b2b");

      busy_cnt = 0;
      repeat (6) cyc(1'b1, 8'($urandom), 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      wait_idle(5 * FRAME, "busy_ovf");

      repeat (5) cyc(1'b1, 8'($urandom), 1'b0);
      cyc(1'b1, 8'($urandom), 1'b1);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      wait_idle(-1, "");

      nxt = 1;
      for (guard = 0; guard < 5000 && nxt <= 10; guard++) begin
         if (mq.size() < DEPTH) begin
            cyc(1'b1, 8'(nxt), 1'b0);
            nxt++;
         end else begin
            cyc(1'b0, 8'h00, 1'b0);
         end
      end
      chk("wrap_all_pushed", 32'(nxt), 32'(11));
      wait_idle(-1, "");

      repeat (300) cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
      wait_idle(-1, "");

      cyc(1'b1, 8'h3A, 1'b0);
      cyc(1'b1, 8'hC4, 1'b0);
      cyc(1'b1, 8'h7E, 1'b0);
      for (guard = 0; guard < 400; guard++) begin
         @(negedge clk);
         if (frame_left != 0 && FRAME - frame_left == 44) break;
      end
      chk("reached_bit3", 32'(guard < 400), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx",    32'(tx),          32'(1));
      chk("midrst_level", 32'(bus.level_o), 32'(0));
      chk("midrst_busy",  32'(bus.busy_o),  32'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2 * FRAME) @(posedge clk);
      #1;

      dbyte     = 8'($urandom);
      busy2_cnt = 0;
      bus2.wr_i    = 1'b1;
      bus2.wdata_i = dbyte;
      @(posedge clk);
      #1 bus2.wr_i = 1'b0;
      chk("def_level_after_push", 32'(bus2.level_o), 32'(1));
      @(posedge clk);
      repeat (DDIV / 2) @(posedge clk);
      #1 chk("def_start", 32'(tx2), 32'(0));
      for (int k = 1; k <= 9; k++) begin
         repeat (DDIV) @(posedge clk);
         #1 chk("def_bit", 32'(tx2), 32'((k == 9) ? 1'b1 : dbyte[k-1]));
      end
      repeat (DDIV) @(posedge clk);
      #1;
      chk("def_busy_cycles", 32'(busy2_cnt), 32'(10 * DDIV));

      chk("sb_drained", 32'(sb_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
